// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with a 2-entry skid buffer (main M, skid S), gated side-effect
// controls and a saturating stall counter. ready_o is a pure flop output (no ready_i path).
module ex_mem_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_W-1:0]     alu_result_i,
  input  logic                  zero_i,
  input  logic [DATA_W-1:0]     store_data_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  reg_write_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic                  mem_to_reg_i,
  input  logic                  flush_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_W-1:0]     alu_result_o,
  output logic                  zero_o,
  output logic [DATA_W-1:0]     store_data_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  reg_write_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic                  mem_to_reg_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  typedef struct packed {
    logic [DATA_W-1:0]     alu_result;
    logic                  zero;
    logic [DATA_W-1:0]     store_data;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
  } payload_t;

  payload_t         m_q, m_d, s_q, s_d, in_pl;
  logic             m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             accept, drain;

  assign in_pl = '{alu_result: alu_result_i, zero: zero_i, store_data: store_data_i,
                   rd_addr: rd_addr_i, reg_write: reg_write_i, mem_read: mem_read_i,
                   mem_write: mem_write_i, mem_to_reg: mem_to_reg_i};

  assign ready_o = ~s_valid_q;
  assign valid_o = m_valid_q;
  assign accept  = valid_i & ready_o;
  assign drain   = m_valid_q & ready_i;

  // Occupancy moves EMPTY(0,0) -> ONE(1,0) -> FULL(1,1); S only fills when M is busy.
  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (flush_i) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q) begin
      if (accept) begin
        m_d       = in_pl;
        m_valid_d = 1'b1;
      end
    end else if (!s_valid_q) begin
      if (accept && drain) begin
        m_d = in_pl;
      end else if (drain) begin
        m_valid_d = 1'b0;
      end else if (accept) begin
        s_d       = in_pl;
        s_valid_d = 1'b1;
      end
    end else if (drain) begin
      m_d       = s_q;
      s_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid_q && !ready_i && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_q         <= '0;
      s_q         <= '0;
      m_valid_q   <= 1'b0;
      s_valid_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      m_q         <= m_d;
      s_q         <= s_d;
      m_valid_q   <= m_valid_d;
      s_valid_q   <= s_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Bubbles and writes to $0 must never reach the register file or memory.
  assign reg_write_o  = m_valid_q & m_q.reg_write & (m_q.rd_addr != '0);
  assign mem_read_o   = m_valid_q & m_q.mem_read;
  assign mem_write_o  = m_valid_q & m_q.mem_write;
  assign mem_to_reg_o = m_valid_q & m_q.mem_to_reg;

  assign alu_result_o = m_q.alu_result;
  assign zero_o       = m_q.zero;
  assign store_data_o = m_q.store_data;
  assign rd_addr_o    = m_q.rd_addr;
  assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: a queue-based reference model checked every cycle,
// plus literal expectations at each scenario step. Uses a 4-bit stall counter.
module tb_ex_mem_pipe;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct {
    logic [DW-1:0] alu;
    logic          zero;
    logic [DW-1:0] store;
    logic [AW-1:0] rd;
    logic          rw, mr, mw, m2r;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_i = 1'b0, ready_o;
  logic [DW-1:0] alu_result_i = '0, store_data_i = '0;
  logic          zero_i = 1'b0;
  logic [AW-1:0] rd_addr_i = '0;
  logic          reg_write_i = 1'b0, mem_read_i = 1'b0, mem_write_i = 1'b0, mem_to_reg_i = 1'b0;
  logic          flush_i = 1'b0, ready_i = 1'b0;
  logic          valid_o, zero_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o;
  logic [DW-1:0] alu_result_o, store_data_o;
  logic [AW-1:0] rd_addr_o;
  logic [CW-1:0] stall_cnt_o;

  int checks = 0;
  int failures = 0;

  beat_t mq[$];
  int    exp_cnt = 0;

  ex_mem_pipe #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .alu_result_i(alu_result_i), .zero_i(zero_i), .store_data_i(store_data_i),
    .rd_addr_i(rd_addr_i), .reg_write_i(reg_write_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .mem_to_reg_i(mem_to_reg_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .alu_result_o(alu_result_o), .zero_o(zero_o),
    .store_data_o(store_data_o), .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] alu, input logic [AW-1:0] rd,
                               input logic rw, input logic mr, input logic mw, input logic m2r,
                               input logic [DW-1:0] st, input logic z);
    valid_i = v; alu_result_i = alu; rd_addr_i = rd; reg_write_i = rw;
    mem_read_i = mr; mem_write_i = mw; mem_to_reg_i = m2r; store_data_i = st; zero_i = z;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a FIFO of at most two beats; ready means fewer than two are held.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_cnt = 0;
    end else begin
      bit acc, drn;
      beat_t b;
      acc = valid_i && (mq.size() < 2);
      drn = (mq.size() > 0) && ready_i;
      if (mq.size() > 0 && !ready_i && exp_cnt < CNT_MAX) exp_cnt++;
      if (flush_i) begin
        mq.delete();
      end else begin
        if (drn) void'(mq.pop_front());
        if (acc) begin
          b = '{alu: alu_result_i, zero: zero_i, store: store_data_i, rd: rd_addr_i,
                rw: reg_write_i, mr: mem_read_i, mw: mem_write_i, m2r: mem_to_reg_i};
          mq.push_back(b);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("cmp_valid", 32'(valid_o), 32'(mq.size() > 0));
      checkOutput("cmp_ready", 32'(ready_o), 32'(mq.size() < 2));
      checkOutput("cmp_stall_cnt", 32'(stall_cnt_o), 32'(exp_cnt));
      if (mq.size() > 0) begin
        checkOutput("cmp_alu", alu_result_o, mq[0].alu);
        checkOutput("cmp_zero", 32'(zero_o), 32'(mq[0].zero));
        checkOutput("cmp_store", store_data_o, mq[0].store);
        checkOutput("cmp_rd", 32'(rd_addr_o), 32'(mq[0].rd));
        checkOutput("cmp_reg_write", 32'(reg_write_o), 32'(mq[0].rw && mq[0].rd != 0));
        checkOutput("cmp_mem_read", 32'(mem_read_o), 32'(mq[0].mr));
        checkOutput("cmp_mem_write", 32'(mem_write_o), 32'(mq[0].mw));
        checkOutput("cmp_mem_to_reg", 32'(mem_to_reg_o), 32'(mq[0].m2r));
      end else begin
        checkOutput("cmp_bubble_ctrl",
                    32'({reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o}), 32'(0));
      end
    end
  end

  initial begin
    // Reset state
    tick(); tick();
    checkOutput("rst_valid", 32'(valid_o), 0);
    checkOutput("rst_ready", 32'(ready_o), 1);
    checkOutput("rst_alu", alu_result_o, 0);
    checkOutput("rst_cnt", 32'(stall_cnt_o), 0);
    rst_n = 1'b1;

    // Single beat with MEM ready
    ready_i = 1'b1;
    applyStimulus(1, 32'h0000_0007, 5'd8, 1, 0, 0, 0, 32'h0, 0);
    tick();
    checkOutput("single_valid", 32'(valid_o), 1);
    checkOutput("single_alu", alu_result_o, 32'h7);
    checkOutput("single_reg_write", 32'(reg_write_o), 1);
    valid_i = 1'b0;
    tick();
    checkOutput("single_valid_after", 32'(valid_o), 0);

    // Backpressure fill A, B, C then release
    ready_i = 1'b0;
    applyStimulus(1, 32'h11, 5'd1, 1, 0, 0, 0, 32'hA, 0);
    tick();
    checkOutput("bp_A_alu", alu_result_o, 32'h11);
    checkOutput("bp_A_ready", 32'(ready_o), 1);
    applyStimulus(1, 32'h22, 5'd2, 1, 0, 0, 0, 32'hB, 1);
    tick();
    checkOutput("bp_B_ready", 32'(ready_o), 0);
    checkOutput("bp_B_cnt", 32'(stall_cnt_o), 1);
    applyStimulus(1, 32'h33, 5'd3, 1, 0, 0, 0, 32'hC, 0);
    tick();
    checkOutput("bp_C_held_alu", alu_result_o, 32'h11);
    checkOutput("bp_C_cnt", 32'(stall_cnt_o), 2);
    tick();
    checkOutput("bp_C_cnt2", 32'(stall_cnt_o), 3);
    ready_i = 1'b1;
    tick();
    checkOutput("bp_out_B", alu_result_o, 32'h22);
    checkOutput("bp_out_B_ready", 32'(ready_o), 1);
    tick();
    checkOutput("bp_out_C", alu_result_o, 32'h33);
    checkOutput("bp_cnt_hold", 32'(stall_cnt_o), 3);
    valid_i = 1'b0;
    tick();
    checkOutput("bp_empty", 32'(valid_o), 0);

    // Streaming accept and drain together
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1, DW'(i), 5'd4, 1, 0, 0, 0, 32'h0, 0);
      tick();
      checkOutput("stream_alu", alu_result_o, 32'(i));
      checkOutput("stream_valid", 32'(valid_o), 1);
      checkOutput("stream_ready", 32'(ready_o), 1);
    end
    valid_i = 1'b0;
    tick();

    // Flush while FULL with a concurrent incoming beat
    ready_i = 1'b0;
    applyStimulus(1, 32'h44, 5'd5, 1, 0, 1, 0, 32'h4, 0);
    tick();
    applyStimulus(1, 32'h55, 5'd6, 1, 0, 1, 0, 32'h5, 0);
    tick();
    checkOutput("flush_full_ready", 32'(ready_o), 0);
    checkOutput("flush_pre_cnt", 32'(stall_cnt_o), 4);
    applyStimulus(1, 32'h66, 5'd7, 1, 0, 1, 0, 32'h6, 0);
    flush_i = 1'b1;
    ready_i = 1'b1;
    tick();
    checkOutput("flush_valid", 32'(valid_o), 0);
    checkOutput("flush_ready", 32'(ready_o), 1);
    checkOutput("flush_cnt", 32'(stall_cnt_o), 4);
    flush_i = 1'b0;
    valid_i = 1'b0;
    tick();
    checkOutput("flush_no_reappear", 32'(valid_o), 0);

    // $0 suppression, full-control beat, all-zero NOOP
    applyStimulus(1, 32'h5, 5'd0, 1, 0, 0, 0, 32'h0, 0);
    tick();
    checkOutput("r0_valid", 32'(valid_o), 1);
    checkOutput("r0_reg_write", 32'(reg_write_o), 0);
    checkOutput("r0_mem_write", 32'(mem_write_o), 0);
    applyStimulus(1, 32'h80, 5'd3, 1, 1, 1, 1, 32'hDEAD_BEEF, 1);
    tick();
    checkOutput("ctl_mem_write", 32'(mem_write_o), 1);
    checkOutput("ctl_store", store_data_o, 32'hDEAD_BEEF);
    applyStimulus(1, 32'h0, 5'd0, 0, 0, 0, 0, 32'h0, 0);
    tick();
    checkOutput("noop_reg_write", 32'(reg_write_o), 0);
    checkOutput("noop_mem_write", 32'(mem_write_o), 0);
    valid_i = 1'b0;
    tick();

    // Asynchronous reset while FULL
    ready_i = 1'b0;
    applyStimulus(1, 32'h77, 5'd9, 1, 0, 0, 0, 32'h0, 0);
    tick();
    applyStimulus(1, 32'h88, 5'd9, 1, 0, 0, 0, 32'h0, 0);
    tick();
    checkOutput("areset_pre_ready", 32'(ready_o), 0);
    valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_valid", 32'(valid_o), 0);
    checkOutput("areset_ready", 32'(ready_o), 1);
    checkOutput("areset_cnt", 32'(stall_cnt_o), 0);
    checkOutput("areset_alu", alu_result_o, 0);
    tick();
    rst_n = 1'b1;

    // Counter saturation
    applyStimulus(1, 32'h99, 5'd1, 1, 0, 0, 0, 32'h0, 0);
    tick();
    valid_i = 1'b0;
    repeat (20) tick();
    checkOutput("sat_cnt", 32'(stall_cnt_o), 32'hF);
    checkOutput("sat_alu", alu_result_o, 32'h99);
    ready_i = 1'b1;
    tick();
    checkOutput("sat_drained", 32'(valid_o), 0);
    checkOutput("sat_cnt_hold", 32'(stall_cnt_o), 32'hF);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
